// File: rtl/rx_arb_pkg.sv
// rtl/rx_arb_pkg.sv - shared types, widths and helpers for the RX round-robin arbiter
package rx_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int BURST_W = 8;
  localparam int MAX_CH  = 32;

  // Fixed-width mask so callers with any channel count can zero-extend against it.
  function automatic logic [MAX_CH-1:0] onehot(input int idx, input int n);
    logic [MAX_CH-1:0] r;
    r = '0;
    if (idx >= 0 && idx < n && idx < MAX_CH) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - circular first-set picker starting after last, with last as final candidate
module rr_pick #(
  parameter int NUM_CHANNELS = 8,
  parameter int GRANT_W      = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] vec,
  input  logic [GRANT_W-1:0]      last,
  output logic [GRANT_W-1:0]      idx,
  output logic                    found
);

  int j;

  // Walk from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    idx   = last;
    found = 1'b0;
    j     = 0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      j = int'(last) + i;
      if (j >= NUM_CHANNELS) j = j - NUM_CHANNELS;
      if (vec[j]) begin
        idx   = GRANT_W'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_arbiter_rr.sv
// rtl/rx_arbiter_rr.sv - burst-holding round-robin arbiter with urgent pre-emption for RX FIFOs
module rx_arbiter_rr
  import rx_arb_pkg::*;
#(
  parameter int NUM_CHANNELS   = 8,
  parameter int GRANT_W        = $clog2(NUM_CHANNELS),
  parameter int BURST_LEN      = 4,
  parameter int URGENT_PREEMPT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] rx_fifo_empty,
  input  logic [NUM_CHANNELS-1:0] rx_fifo_almost_full,
  input  logic                    read_periph_data,
  output logic [GRANT_W-1:0]      grant,
  output logic                    grant_valid,
  output logic [BURST_W-1:0]      burst_cnt,
  output logic                    err_read
);

  state_t                    state_q;
  logic [GRANT_W-1:0]        grant_q;
  logic [GRANT_W-1:0]        last_q;
  logic [BURST_W-1:0]        burst_q;
  logic                      err_q;

  logic [NUM_CHANNELS-1:0]   req;
  logic [NUM_CHANNELS-1:0]   urg;
  logic [MAX_CH-1:0]         urg_ext;
  logic [GRANT_W-1:0]        urg_idx;
  logic [GRANT_W-1:0]        req_idx;
  logic                      urg_found;
  logic                      req_found;
  logic [GRANT_W-1:0]        sel_idx;
  logic                      gempty;
  logic                      trig_a;
  logic                      trig_b;
  logic                      trig_c;
  logic                      rearb;

  assign req     = ~rx_fifo_empty;
  assign urg     = rx_fifo_almost_full & req;
  assign urg_ext = MAX_CH'(urg);

  rr_pick #(.NUM_CHANNELS(NUM_CHANNELS), .GRANT_W(GRANT_W)) u_pick_urg (
    .vec   (urg),
    .last  (last_q),
    .idx   (urg_idx),
    .found (urg_found)
  );

  rr_pick #(.NUM_CHANNELS(NUM_CHANNELS), .GRANT_W(GRANT_W)) u_pick_req (
    .vec   (req),
    .last  (last_q),
    .idx   (req_idx),
    .found (req_found)
  );

  assign sel_idx = urg_found ? urg_idx : req_idx;
  assign gempty  = rx_fifo_empty[grant_q];

  // Burst end, urgent cut-in on a non-urgent holder, or the holder drained without being read.
  assign trig_a = read_periph_data && (burst_q == BURST_W'(BURST_LEN - 1));
  assign trig_b = read_periph_data && (URGENT_PREEMPT != 0) && !urg[grant_q] &&
                  (|(urg_ext & ~onehot(int'(grant_q), NUM_CHANNELS)));
  assign trig_c = gempty && !read_periph_data;
  assign rearb  = trig_a || trig_b || trig_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GRANT_W'(NUM_CHANNELS - 1);
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= read_periph_data && ((state_q == IDLE) || gempty);
      case (state_q)
        IDLE: begin
          if (req_found) begin
            state_q <= GRANT;
            grant_q <= sel_idx;
            last_q  <= sel_idx;
            burst_q <= '0;
          end
        end
        GRANT: begin
          if (rearb) begin
            burst_q <= '0;
            if (req_found) begin
              grant_q <= sel_idx;
              last_q  <= sel_idx;
            end else begin
              state_q <= IDLE;
            end
          end else if (read_periph_data && (burst_q != '1)) begin
            burst_q <= burst_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == GRANT);
  assign burst_cnt   = burst_q;
  assign err_read    = err_q;

endmodule

// File: tb/tb_rx_arbiter_rr.sv
// tb/tb_rx_arbiter_rr.sv - scoreboard bench for rx_arbiter_rr (8 channels, burst 4)
module tb_rx_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_fifo_empty = 8'hFF;
  logic [7:0] rx_fifo_almost_full = 8'h00;
  logic       read_periph_data = 1'b0;

  logic [2:0] grant, np_grant;
  logic       grant_valid, np_grant_valid;
  logic [7:0] burst_cnt, np_burst_cnt;
  logic       err_read, np_err_read;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] empty;
    logic [7:0] af;
    logic       rd;
    logic [2:0] g;
    logic       v;
    logic [7:0] b;
    logic       e;
    logic       np_chk;
    logic [2:0] np_g;
    logic [7:0] np_b;
  } step_t;

  step_t sb[$];

  always #5 clk = ~clk;

  rx_arbiter_rr #(.NUM_CHANNELS(8), .BURST_LEN(4), .URGENT_PREEMPT(1)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_fifo_empty       (rx_fifo_empty),
    .rx_fifo_almost_full (rx_fifo_almost_full),
    .read_periph_data    (read_periph_data),
    .grant               (grant),
    .grant_valid         (grant_valid),
    .burst_cnt           (burst_cnt),
    .err_read            (err_read)
  );

  rx_arbiter_rr #(.NUM_CHANNELS(8), .BURST_LEN(4), .URGENT_PREEMPT(0)) dut_np (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_fifo_empty       (rx_fifo_empty),
    .rx_fifo_almost_full (rx_fifo_almost_full),
    .read_periph_data    (read_periph_data),
    .grant               (np_grant),
    .grant_valid         (np_grant_valid),
    .burst_cnt           (np_burst_cnt),
    .err_read            (np_err_read)
  );

  function automatic step_t mk(input logic [7:0] empty, input logic [7:0] af, input logic rd,
                               input logic [2:0] g, input logic v, input logic [7:0] b,
                               input logic e);
    step_t s;
    s.empty = empty; s.af = af; s.rd = rd;
    s.g = g; s.v = v; s.b = b; s.e = e;
    s.np_chk = 1'b0; s.np_g = 3'd0; s.np_b = 8'd0;
    return s;
  endfunction

  function automatic step_t mk_np(input logic [7:0] empty, input logic [7:0] af, input logic rd,
                                  input logic [2:0] g, input logic [7:0] b,
                                  input logic [2:0] ng, input logic [7:0] nb);
    step_t s;
    s = mk(empty, af, rd, g, 1'b1, b, 1'b0);
    s.np_chk = 1'b1; s.np_g = ng; s.np_b = nb;
    return s;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, and land #1 after the capturing edge.
  task automatic run_step(input step_t s);
    rx_fifo_empty       = s.empty;
    rx_fifo_almost_full = s.af;
    read_periph_data    = s.rd;
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t tbl[$];
    step_t x;
    rst_n = 1'b0;
    rx_fifo_empty = 8'hFF; rx_fifo_almost_full = 8'h00; read_periph_data = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (grant !== 3'd0 || grant_valid !== 1'b0 || burst_cnt !== 8'd0 || err_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got g=%0d v=%0d b=%0d e=%0d, want 0 0 0 0",
               grant, grant_valid, burst_cnt, err_read);
    end
    rst_n = 1'b1;
    tbl.push_back(mk(8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0));
    tbl.push_back(mk(8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0));
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      x = sb.pop_front();
      n_tests++;
      if (grant !== x.g || grant_valid !== x.v || burst_cnt !== x.b || err_read !== x.e) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got g=%0d v=%0d b=%0d e=%0d, want g=%0d v=%0d b=%0d e=%0d",
                 i, grant, grant_valid, burst_cnt, err_read, x.g, x.v, x.b, x.e);
      end
    end
  endtask

  task automatic test_burst_rotate();
    step_t tbl[$];
    step_t x;
    tbl.push_back(mk(8'hEB, 8'h00, 1'b0, 3'd2, 1'b1, 8'd0, 1'b0));
    tbl.push_back(mk(8'hEB, 8'h00, 1'b1, 3'd2, 1'b1, 8'd1, 1'b0));
    tbl.push_back(mk(8'hEB, 8'h00, 1'b1, 3'd2, 1'b1, 8'd2, 1'b0));
    tbl.push_back(mk(8'hEB, 8'h00, 1'b1, 3'd2, 1'b1, 8'd3, 1'b0));
    tbl.push_back(mk(8'hEB, 8'h00, 1'b1, 3'd4, 1'b1, 8'd0, 1'b0));
    tbl.push_back(mk(8'hEB, 8'h00, 1'b1, 3'd4, 1'b1, 8'd1, 1'b0));
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      x = sb.pop_front();
      n_tests++;
      if (grant !== x.g || grant_valid !== x.v || burst_cnt !== x.b || err_read !== x.e) begin
        n_fail++;
        $display("FAIL burst[%0d]: got g=%0d v=%0d b=%0d e=%0d, want g=%0d v=%0d b=%0d e=%0d",
                 i, grant, grant_valid, burst_cnt, err_read, x.g, x.v, x.b, x.e);
      end
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (grant !== 3'd0 || grant_valid !== 1'b0 || burst_cnt !== 8'd0 || err_read !== 1'b0) begin
      n_fail++;
      $display("FAIL midburst_reset: got g=%0d v=%0d b=%0d e=%0d, want 0 0 0 0",
               grant, grant_valid, burst_cnt, err_read);
    end
    read_periph_data = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    step_t tbl[$];
    step_t x;
    tbl.push_back(mk(8'h7F, 8'h00, 1'b0, 3'd7, 1'b1, 8'd0, 1'b0));
    tbl.push_back(mk(8'h7D, 8'h00, 1'b1, 3'd7, 1'b1, 8'd1, 1'b0));
    tbl.push_back(mk(8'h7D, 8'h00, 1'b1, 3'd7, 1'b1, 8'd2, 1'b0));
    tbl.push_back(mk(8'h7D, 8'h00, 1'b1, 3'd7, 1'b1, 8'd3, 1'b0));
    tbl.push_back(mk(8'h7D, 8'h00, 1'b1, 3'd1, 1'b1, 8'd0, 1'b0));
    tbl.push_back(mk(8'h7F, 8'h00, 1'b0, 3'd7, 1'b1, 8'd0, 1'b0));
    tbl.push_back(mk(8'h7F, 8'h00, 1'b1, 3'd7, 1'b1, 8'd1, 1'b0));
    tbl.push_back(mk(8'h7F, 8'h00, 1'b1, 3'd7, 1'b1, 8'd2, 1'b0));
    tbl.push_back(mk(8'h7F, 8'h00, 1'b1, 3'd7, 1'b1, 8'd3, 1'b0));
    tbl.push_back(mk(8'h7F, 8'h00, 1'b1, 3'd7, 1'b1, 8'd0, 1'b0));
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      x = sb.pop_front();
      n_tests++;
      if (grant !== x.g || grant_valid !== x.v || burst_cnt !== x.b || err_read !== x.e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got g=%0d v=%0d b=%0d e=%0d, want g=%0d v=%0d b=%0d e=%0d",
                 i, grant, grant_valid, burst_cnt, err_read, x.g, x.v, x.b, x.e);
      end
    end
  endtask

  task automatic test_urgent();
    step_t tbl[$];
    step_t x;
    rst_n = 1'b0;
    rx_fifo_empty = 8'hFF; rx_fifo_almost_full = 8'h00; read_periph_data = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tbl.push_back(mk_np(8'hFB, 8'h00, 1'b0, 3'd2, 8'd0, 3'd2, 8'd0));
    tbl.push_back(mk_np(8'hDB, 8'h20, 1'b0, 3'd2, 8'd0, 3'd2, 8'd0));
    tbl.push_back(mk_np(8'hDB, 8'h20, 1'b1, 3'd5, 8'd0, 3'd2, 8'd1));
    tbl.push_back(mk_np(8'hDB, 8'h20, 1'b1, 3'd5, 8'd1, 3'd2, 8'd2));
    tbl.push_back(mk_np(8'hDB, 8'h20, 1'b1, 3'd5, 8'd2, 3'd2, 8'd3));
    tbl.push_back(mk_np(8'hDB, 8'h20, 1'b1, 3'd5, 8'd3, 3'd5, 8'd0));
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      x = sb.pop_front();
      n_tests++;
      if (grant !== x.g || grant_valid !== x.v || burst_cnt !== x.b || err_read !== x.e ||
          (x.np_chk && (np_grant !== x.np_g || np_grant_valid !== 1'b1 || np_burst_cnt !== x.np_b))) begin
        n_fail++;
        $display("FAIL urgent[%0d]: got g=%0d v=%0d b=%0d e=%0d np_g=%0d np_b=%0d, want g=%0d v=%0d b=%0d e=%0d np_g=%0d np_b=%0d",
                 i, grant, grant_valid, burst_cnt, err_read, np_grant, np_burst_cnt,
                 x.g, x.v, x.b, x.e, x.np_g, x.np_b);
      end
    end
  endtask

  task automatic test_drain();
    step_t tbl[$];
    step_t x;
    tbl.push_back(mk(8'hEF, 8'h00, 1'b0, 3'd4, 1'b1, 8'd0, 1'b0));
    tbl.push_back(mk(8'hFF, 8'h00, 1'b0, 3'd4, 1'b0, 8'd0, 1'b0));
    tbl.push_back(mk(8'hFF, 8'h00, 1'b0, 3'd4, 1'b0, 8'd0, 1'b0));
    tbl.push_back(mk(8'hEF, 8'h00, 1'b0, 3'd4, 1'b1, 8'd0, 1'b0));
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      x = sb.pop_front();
      n_tests++;
      if (grant !== x.g || grant_valid !== x.v || burst_cnt !== x.b || err_read !== x.e) begin
        n_fail++;
        $display("FAIL drain[%0d]: got g=%0d v=%0d b=%0d e=%0d, want g=%0d v=%0d b=%0d e=%0d",
                 i, grant, grant_valid, burst_cnt, err_read, x.g, x.v, x.b, x.e);
      end
    end
  endtask

  task automatic test_errors();
    step_t tbl[$];
    step_t x;
    tbl.push_back(mk(8'hFF, 8'h00, 1'b0, 3'd4, 1'b0, 8'd0, 1'b0));
    tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 3'd4, 1'b0, 8'd0, 1'b1));
    tbl.push_back(mk(8'hFF, 8'h00, 1'b0, 3'd4, 1'b0, 8'd0, 1'b0));
    tbl.push_back(mk(8'hEF, 8'h00, 1'b0, 3'd4, 1'b1, 8'd0, 1'b0));
    tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 3'd4, 1'b1, 8'd1, 1'b1));
    tbl.push_back(mk(8'hFF, 8'h00, 1'b0, 3'd4, 1'b0, 8'd0, 1'b0));
    foreach (tbl[i]) begin
      run_step(tbl[i]);
      x = sb.pop_front();
      n_tests++;
      if (grant !== x.g || grant_valid !== x.v || burst_cnt !== x.b || err_read !== x.e) begin
        n_fail++;
        $display("FAIL errors[%0d]: got g=%0d v=%0d b=%0d e=%0d, want g=%0d v=%0d b=%0d e=%0d",
                 i, grant, grant_valid, burst_cnt, err_read, x.g, x.v, x.b, x.e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst_rotate();
    test_wrap();
    test_urgent();
    test_drain();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
